// File: rtl/neuron_mac.sv
// Multiply-accumulate neuron: N_INPUTS signed x*weight beats plus bias, optional ReLU, saturated output.
// Latency: result registered on the edge accepting the last beat; min period N_INPUTS+1 cycles per vector.
// Backpressure: in_ready drops while a result is held; held until out_valid && out_ready.
module neuron_mac #(
   parameter int DATA_W   = 8,
   parameter int N_INPUTS = 4,
   parameter int ACC_W    = 20,
   parameter int OUT_W    = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic signed [DATA_W-1:0]   x,
   input  logic signed [DATA_W-1:0]   weight,
   input  logic signed [2*DATA_W-1:0] bias,
   input  logic                       relu_en,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic signed [OUT_W-1:0]    out,
   output logic                       sat
);

   typedef enum logic {ACCUM, HOLD} state_t;

   localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_INPUTS - 1);

   // Output range expressed at accumulator width so comparisons never truncate.
   localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   state_t                     state, state_nxt;
   logic [CNT_W-1:0]           cnt;
   logic signed [ACC_W-1:0]    acc;
   logic                       relu_q;

   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0]    prod_ext, base, sum, act;
   logic                       accept, first_beat, last_beat, relu_eff;
   logic signed [OUT_W-1:0]    out_nxt;
   logic                       sat_nxt;

   // Handshake flags are pure state decodes: no path from in_valid/out_ready.
   assign in_ready  = (state == ACCUM);
   assign out_valid = (state == HOLD);

   assign accept     = in_valid && in_ready;
   assign first_beat = (cnt == '0);
   assign last_beat  = (cnt == CNT_LAST);

   // Full-precision signed product, then sign-extended into the accumulator.
   assign prod     = (2*DATA_W)'(x) * (2*DATA_W)'(weight);
   assign prod_ext = ACC_W'(prod);
   assign base     = first_beat ? ACC_W'(bias) : acc;
   assign sum      = base + prod_ext;

   // With a single-beat vector the first beat is also the last, so use live relu_en.
   assign relu_eff = first_beat ? relu_en : relu_q;

   // Activation and saturation of the final sum.
   always_comb begin
      act     = sum;
      out_nxt = '0;
      sat_nxt = 1'b0;
      if (relu_eff && sum < 0)
         act = '0;
      if (act > OUT_MAX) begin
         out_nxt = OUT_MAX[OUT_W-1:0];
         sat_nxt = 1'b1;
      end else if (act < OUT_MIN) begin
         out_nxt = OUT_MIN[OUT_W-1:0];
         sat_nxt = 1'b1;
      end else begin
         out_nxt = act[OUT_W-1:0];
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= ACCUM;
      else
         state <= state_nxt;
   end

   // Next state: enter HOLD on the last beat, leave on output handshake.
   always_comb begin
      state_nxt = state;
      case (state)
         ACCUM: if (accept && last_beat) state_nxt = HOLD;
         HOLD:  if (out_ready)           state_nxt = ACCUM;
         default: state_nxt = ACCUM;
      endcase
   end

   // Beat counter, accumulator, latched ReLU select and registered result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         acc    <= '0;
         relu_q <= 1'b0;
         out    <= '0;
         sat    <= 1'b0;
      end else if (accept) begin
         acc <= sum;
         if (first_beat)
            relu_q <= relu_en;
         if (last_beat) begin
            cnt <= '0;
            out <= out_nxt;
            sat <= sat_nxt;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_neuron_mac.sv
// Self-checking bench for neuron_mac: table vectors, hand-written corner sequences, random vs model.
// Inputs driven 1 time unit after the rising edge; outputs sampled at that same point.
// Later beats of every vector carry a different bias and inverted relu_en, which must be ignored.
module tb_neuron_mac;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic signed [7:0] x;
   logic signed [7:0] weight;
   logic signed [15:0] bias;
   logic              relu_en;
   logic              out_valid;
   logic              out_ready;
   logic signed [15:0] out;
   logic              sat;

   int checks = 0;
   int errors = 0;

   neuron_mac #(.DATA_W(8), .N_INPUTS(4), .ACC_W(20), .OUT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .x(x), .weight(weight), .bias(bias), .relu_en(relu_en),
      .out_valid(out_valid), .out_ready(out_ready), .out(out), .sat(sat)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0][7:0] xs;
      logic [3:0][7:0] ws;
      logic [15:0]     b;
      logic            r;
      logic [1:0]      gap;
      logic [15:0]     eo;
      logic            es;
   } vec_t;

   vec_t tbl [11];

   task automatic check(input string nm, input int act, input int exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
      end
   endtask

   function automatic logic [3:0][7:0] pack4(input int a, input int b, input int c, input int d);
      logic [3:0][7:0] p;
      p[0] = 8'(a); p[1] = 8'(b); p[2] = 8'(c); p[3] = 8'(d);
      return p;
   endfunction

   function automatic vec_t mk(input logic [3:0][7:0] xs, input logic [3:0][7:0] ws, input int b,
                               input bit r, input int gap, input int eo, input bit es);
      vec_t v;
      v.xs = xs; v.ws = ws; v.b = 16'(b); v.r = r; v.gap = 2'(gap); v.eo = 16'(eo); v.es = es;
      return v;
   endfunction

   // Reference: plain integer dot product plus bias, ReLU, then clamp to 16-bit signed.
   function automatic void model(input logic [3:0][7:0] xs, input logic [3:0][7:0] ws,
                                 input logic [15:0] b, input logic r,
                                 output int eo, output int es);
      int s;
      s = int'($signed(b));
      for (int i = 0; i < 4; i++)
         s += int'($signed(xs[i])) * int'($signed(ws[i]));
      if (r && s < 0) s = 0;
      es = 0;
      if (s > 32767)       begin eo = 32767;  es = 1; end
      else if (s < -32768) begin eo = -32768; es = 1; end
      else                 eo = s;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Sends one vector, then checks the result one cycle after the last beat.
   // With out_ready high it also checks in_ready is low for exactly one cycle.
   task automatic run_vec(input logic [3:0][7:0] xs, input logic [3:0][7:0] ws,
                          input logic [15:0] b, input logic r, input int gap,
                          input int eo, input int es, input int id);
      int n;
      for (int i = 0; i < 4; i++) begin
         n = 0;
         while (!in_ready && n < 50) begin tick(); n++; end
         if (!in_ready) check($sformatf("vec%0d_in_ready_wait", id), 0, 1);
         in_valid = 1'b1;
         x        = xs[i];
         weight   = ws[i];
         bias     = (i == 0) ? b : (b ^ 16'h5A5A);
         relu_en  = (i == 0) ? r : ~r;
         tick();
         in_valid = 1'b0;
         x        = 8'sh7F;
         weight   = 8'sh7F;
         if (i == 1) repeat (gap) tick();
      end
      check($sformatf("vec%0d_out_valid", id), out_valid, 1);
      check($sformatf("vec%0d_out", id), out, eo);
      check($sformatf("vec%0d_sat", id), sat, es);
      if (out_ready) begin
         check($sformatf("vec%0d_in_ready_hold", id), in_ready, 0);
         tick();
         check($sformatf("vec%0d_in_ready_after", id), in_ready, 1);
         check($sformatf("vec%0d_out_valid_after", id), out_valid, 0);
      end
   endtask

   initial begin
      logic [3:0][7:0] bx, bw, rx, rw;
      logic [15:0] rb;
      logic rr;
      int eo, es;

      bx = pack4(2, 64, 0, 1);
      bw = pack4(2, 64, 1, 2);
      tbl[0]  = mk(bx, bw, 5, 0, 0, 4107, 0);
      tbl[1]  = mk(bx, bw, 5, 0, 2, 4107, 0);
      tbl[2]  = mk(pack4(127, 127, 127, 127), pack4(127, 127, 127, 127), 0, 0, 0, 32767, 1);
      tbl[3]  = mk(pack4(-128, -128, -128, -128), pack4(127, 127, 127, 127), 0, 0, 0, -32768, 1);
      tbl[4]  = mk(pack4(-128, -128, -128, -128), pack4(-128, -128, -128, -128), -32768, 0, 1, 32767, 1);
      tbl[5]  = mk(pack4(-127, 0, 0, 0), pack4(2, 1, 1, 1), 0, 1, 0, 0, 0);
      tbl[6]  = mk(pack4(-127, 0, 0, 0), pack4(2, 1, 1, 1), 0, 0, 0, -254, 0);
      tbl[7]  = mk(pack4(0, 0, 0, 0), pack4(0, 0, 0, 0), -100, 1, 0, 0, 0);
      tbl[8]  = mk(pack4(0, 0, 0, 0), pack4(0, 0, 0, 0), 32767, 0, 0, 32767, 0);
      tbl[9]  = mk(pack4(0, 0, 0, 0), pack4(0, 0, 0, 0), -32768, 0, 0, -32768, 0);
      tbl[10] = mk(pack4(1, 0, 0, 0), pack4(1, 0, 0, 0), 32767, 0, 0, 32767, 1);

      rst = 1'b1; in_valid = 1'b0; x = '0; weight = '0; bias = '0; relu_en = 1'b0; out_ready = 1'b1;
      tick(); tick();
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out", out, 0);
      check("rst_sat", sat, 0);
      rst = 1'b0;
      tick();

      // Table vectors, back to back.
      for (int t = 0; t < 11; t++)
         run_vec(tbl[t].xs, tbl[t].ws, tbl[t].b, tbl[t].r, int'(tbl[t].gap),
                 int'($signed(tbl[t].eo)), int'(tbl[t].es), t);

      // Back-pressure: hold result 3 cycles while offering a beat that must not be taken.
      out_ready = 1'b0;
      run_vec(bx, bw, 16'd5, 1'b0, 0, 4107, 0, 100);
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1; x = 8'sd100; weight = 8'sd100; bias = 16'sd0; relu_en = 1'b0;
         tick();
         check($sformatf("bp_out_stable%0d", k), out, 4107);
         check($sformatf("bp_in_ready%0d", k), in_ready, 0);
         check($sformatf("bp_out_valid%0d", k), out_valid, 1);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      check("bp_release_in_ready", in_ready, 1);
      check("bp_release_out_valid", out_valid, 0);
      run_vec(tbl[6].xs, tbl[6].ws, tbl[6].b, tbl[6].r, 0, -254, 0, 101);

      // Asynchronous reset mid-cycle while a result is held.
      out_ready = 1'b0;
      run_vec(bx, bw, 16'd5, 1'b0, 0, 4107, 0, 102);
      #2 rst = 1'b1;
      #1;
      check("arst_out_valid", out_valid, 0);
      check("arst_out", out, 0);
      check("arst_sat", sat, 0);
      check("arst_in_ready", in_ready, 1);
      rst = 1'b0;
      out_ready = 1'b1;
      tick();

      // Reset mid-vector: two beats discarded, then a clean vector.
      for (int k = 0; k < 2; k++) begin
         in_valid = 1'b1; x = 8'sd50; weight = 8'sd50; bias = 16'sd1000; relu_en = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      tick();
      run_vec(bx, bw, 16'd5, 1'b0, 0, 4107, 0, 103);
      run_vec(tbl[2].xs, tbl[2].ws, tbl[2].b, 1'b0, 0, 32767, 1, 104);
      run_vec(bx, bw, 16'd5, 1'b0, 0, 4107, 0, 105);

      // Random vectors against the model.
      for (int t = 0; t < 30; t++) begin
         for (int i = 0; i < 4; i++) begin
            rx[i] = 8'($urandom);
            rw[i] = 8'($urandom);
         end
         rb = 16'($urandom);
         rr = 1'($urandom);
         model(rx, rw, rb, rr, eo, es);
         run_vec(rx, rw, rb, rr, int'($urandom_range(0, 2)), eo, es, 200 + t);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global watchdog so the bench always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
